decode_stage: RTL and testbench

//   Registered instruction-decode pipeline stage between fetch and execute.
//   - Classifies each 16-bit word into a GROUP_* code (cpu_data.v) and splits out operand fields.
//   - Adds over the combinational decoder: valid/ready handshake, a PC side-band and flush.
//   - Adds an EXT prefix word (word[4:0]=5'b11010) that widens the next word's immediate or jump offset.

---
 rtl/decode_stage.sv | 175 +++++++++++++++++
 tb/tb_decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered instruction-decode pipeline stage sitting between fetch and execute.
// Classifies each 16-bit word into a group code, splits out operand fields and
// supports an EXT prefix word (word[4:0] = 5'b11010) that widens the immediate
// or jump offset of the word that follows it.
// Group codes (local copy of the cpu_data values):
//   0 none/illegal, 1 CRVMATH, 2 RJMP, 3 CRRMATH, 4 CRSMATH, 5 SFLAG, 6 UFLAG,
//   7 SPECIAL, 8 WRRMATH, 9 WRRMATH_MEM, 10 WRSMATH, 11 WRSMATH_STACK
module decode_stage #(
    parameter int ADDR_WIDTH = 16,
    parameter bit EXT_ENABLE = 1'b1,
    localparam int VAL_WIDTH = EXT_ENABLE ? 16 : 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [15:0]           in_word,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            out_group,
    output logic [3:0]            out_operator,
    output logic [2:0]            out_rgv,
    output logic [2:0]            out_rg1,
    output logic [2:0]            out_rg2,
    output logic [VAL_WIDTH-1:0]  out_val,
    output logic [ADDR_WIDTH-1:0] out_rel,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_ext,
    output logic                  out_illegal
);

    localparam logic [3:0] GROUP_NONE          = 4'd0;
    localparam logic [3:0] GROUP_CRVMATH       = 4'd1;
    localparam logic [3:0] GROUP_RJMP          = 4'd2;
    localparam logic [3:0] GROUP_CRRMATH       = 4'd3;
    localparam logic [3:0] GROUP_CRSMATH       = 4'd4;
    localparam logic [3:0] GROUP_SFLAG         = 4'd5;
    localparam logic [3:0] GROUP_UFLAG         = 4'd6;
    localparam logic [3:0] GROUP_SPECIAL       = 4'd7;
    localparam logic [3:0] GROUP_WRRMATH       = 4'd8;
    localparam logic [3:0] GROUP_WRRMATH_MEM   = 4'd9;
    localparam logic [3:0] GROUP_WRSMATH       = 4'd10;
    localparam logic [3:0] GROUP_WRSMATH_STACK = 4'd11;

    typedef enum logic {
        FIRST,
        PREFIX
    } state_t;

    state_t                  state;
    logic [7:0]              prefix_hi;
    logic [ADDR_WIDTH-1:0]   prefix_pc;

    logic                    accept;
    logic                    is_prefix;
    logic                    ext_group;
    logic [3:0]              op;
    logic [3:0]              dec_group;
    logic                    dec_illegal;
    logic [VAL_WIDTH-1:0]    val_norm;
    logic [VAL_WIDTH-1:0]    val_ext;
    logic [ADDR_WIDTH-1:0]   rel_norm;
    logic [ADDR_WIDTH-1:0]   rel_ext;

    // A flush cycle never consumes the fetched word; otherwise accept whenever
    // the output register is empty or being drained this cycle.
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign op        = in_word[15:12];
    assign is_prefix = EXT_ENABLE && (in_word[4:0] == 5'b11010);
    assign ext_group = (dec_group == GROUP_CRVMATH) || (dec_group == GROUP_RJMP);

    // Immediate and offset in both plain and prefix-widened forms; the offsets
    // are sign-extended (or truncated) to the address width.
    assign val_norm = VAL_WIDTH'(in_word[11:4]);
    assign val_ext  = VAL_WIDTH'({prefix_hi, in_word[11:4]});
    assign rel_norm = ADDR_WIDTH'($signed(in_word[15:5]));
    assign rel_ext  = ADDR_WIDTH'($signed({prefix_hi, in_word[15:5]}));

    // Group classification of the incoming word from its low five bits and opcode.
    always_comb begin
        dec_group   = GROUP_NONE;
        dec_illegal = 1'b0;
        casez (in_word[4:0])
            5'b0????: dec_group = GROUP_CRVMATH;
            5'b10???: dec_group = GROUP_RJMP;
            5'b11100: dec_group = GROUP_CRRMATH;
            5'b11110: dec_group = GROUP_CRSMATH;
            5'b11000: dec_group = GROUP_SFLAG;
            5'b11001: dec_group = GROUP_UFLAG;
            5'b11011: dec_group = GROUP_SPECIAL;
            5'b11101: begin
                if (op == 4'b1011 || op == 4'b1111) begin
                    dec_group = GROUP_WRRMATH;
                end else if (op[3]) begin
                    dec_group = GROUP_WRRMATH_MEM;
                end else begin
                    dec_group = GROUP_WRRMATH;
                end
            end
            5'b11111: begin
                if (op[2:0] == 3'b111) begin
                    dec_group = GROUP_WRSMATH_STACK;
                end else begin
                    dec_group = GROUP_WRSMATH;
                end
            end
            default: begin
                dec_group   = GROUP_NONE;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Prefix FSM and output register; a word after a prefix always reports the
    // prefix PC and out_ext, and is illegal unless it is CRVMATH or RJMP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FIRST;
            prefix_hi    <= '0;
            prefix_pc    <= '0;
            out_valid    <= 1'b0;
            out_group    <= '0;
            out_operator <= '0;
            out_rgv      <= '0;
            out_rg1      <= '0;
            out_rg2      <= '0;
            out_val      <= '0;
            out_rel      <= '0;
            out_pc       <= '0;
            out_ext      <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= FIRST;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (state == FIRST && is_prefix) begin
                    prefix_hi <= in_word[15:8];
                    prefix_pc <= in_pc;
                    state     <= PREFIX;
                end else begin
                    out_valid    <= 1'b1;
                    out_group    <= dec_group;
                    out_operator <= in_word[15:12];
                    out_rgv      <= in_word[3:1];
                    out_rg1      <= in_word[7:5];
                    out_rg2      <= in_word[10:8];
                    out_val      <= val_norm;
                    out_rel      <= rel_norm;
                    out_pc       <= in_pc;
                    out_ext      <= 1'b0;
                    out_illegal  <= dec_illegal;
                    if (state == PREFIX) begin
                        out_pc  <= prefix_pc;
                        out_ext <= 1'b1;
                        state   <= FIRST;
                        if (ext_group) begin
                            out_val <= val_ext;
                            out_rel <= rel_ext;
                        end else begin
                            out_illegal <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed steps followed by a random phase, all
// checked against a queue-based behavioural model of the decode rules.
module tb_decode_stage;

    localparam int AW = 20;

    localparam logic [3:0] G_NONE  = 4'd0;
    localparam logic [3:0] G_CRV   = 4'd1;
    localparam logic [3:0] G_RJMP  = 4'd2;
    localparam logic [3:0] G_CRR   = 4'd3;
    localparam logic [3:0] G_CRS   = 4'd4;
    localparam logic [3:0] G_SFLAG = 4'd5;
    localparam logic [3:0] G_UFLAG = 4'd6;
    localparam logic [3:0] G_SPEC  = 4'd7;
    localparam logic [3:0] G_WRR   = 4'd8;
    localparam logic [3:0] G_WRRM  = 4'd9;
    localparam logic [3:0] G_WRS   = 4'd10;
    localparam logic [3:0] G_WRSS  = 4'd11;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [15:0]   in_word;
    logic [AW-1:0] in_pc;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_group;
    logic [3:0]    out_operator;
    logic [2:0]    out_rgv;
    logic [2:0]    out_rg1;
    logic [2:0]    out_rg2;
    logic [15:0]   out_val;
    logic [AW-1:0] out_rel;
    logic [AW-1:0] out_pc;
    logic          out_ext;
    logic          out_illegal;

    typedef struct {
        logic [3:0]    group;
        logic [3:0]    op;
        logic [2:0]    rgv;
        logic [2:0]    rg1;
        logic [2:0]    rg2;
        logic [15:0]   val;
        logic [AW-1:0] rel;
        logic [AW-1:0] pc;
        logic          ext;
        logic          ill;
    } bundle_t;

    bundle_t       q[$];
    bit            pend;
    int            ph;
    logic [AW-1:0] ppc;
    int            total = 0;
    int            bad = 0;

    decode_stage #(.ADDR_WIDTH(AW), .EXT_ENABLE(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_word(in_word), .in_pc(in_pc), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_group(out_group), .out_operator(out_operator),
        .out_rgv(out_rgv), .out_rg1(out_rg1), .out_rg2(out_rg2),
        .out_val(out_val), .out_rel(out_rel), .out_pc(out_pc),
        .out_ext(out_ext), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] groupOf(input logic [15:0] w);
        int low5;
        int op;
        low5 = int'(w) % 32;
        op   = int'(w) / 4096;
        if (low5 < 16) return G_CRV;
        if (low5 < 24) return G_RJMP;
        case (low5)
            24: return G_SFLAG;
            25: return G_UFLAG;
            27: return G_SPEC;
            28: return G_CRR;
            29: return (op == 11 || op == 15) ? G_WRR : ((op >= 8) ? G_WRRM : G_WRR);
            30: return G_CRS;
            31: return (op % 8 == 7) ? G_WRSS : G_WRS;
            default: return G_NONE;
        endcase
    endfunction

    function automatic bundle_t plainBundle(input logic [15:0] w, input logic [AW-1:0] pc);
        bundle_t b;
        int off;
        b.group = groupOf(w);
        b.op    = 4'(int'(w) / 4096);
        b.rgv   = 3'((int'(w) / 2) % 8);
        b.rg1   = 3'((int'(w) / 32) % 8);
        b.rg2   = 3'((int'(w) / 256) % 8);
        b.val   = 16'((int'(w) / 16) % 256);
        off = int'(w) / 32;
        if (off >= 1024) off -= 2048;
        b.rel = AW'(off);
        b.pc  = pc;
        b.ext = 1'b0;
        b.ill = (int'(w) % 32 == 26);
        return b;
    endfunction

    task automatic modelAccept(input logic [15:0] w, input logic [AW-1:0] pc);
        bundle_t b;
        int off;
        if (!pend) begin
            if (int'(w) % 32 == 26) begin
                pend = 1'b1;
                ph   = int'(w) / 256;
                ppc  = pc;
            end else begin
                q.push_back(plainBundle(w, pc));
            end
        end else begin
            pend  = 1'b0;
            b     = plainBundle(w, pc);
            b.pc  = ppc;
            b.ext = 1'b1;
            if (b.group == G_CRV || b.group == G_RJMP) begin
                b.val = 16'(ph * 256 + (int'(w) / 16) % 256);
                off = ph * 2048 + int'(w) / 32;
                if (off >= 262144) off -= 524288;
                b.rel = AW'(off);
            end else begin
                b.ill = 1'b1;
            end
            q.push_back(b);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    // One clock: sample at the falling edge, compare against the model, then
    // advance the model with the handshakes that the rising edge will perform.
    task automatic tick();
        bit ev;
        bit eir;
        @(negedge clk);
        ev  = (q.size() != 0);
        eir = !flush && (!ev || out_ready);
        checkOutput("out_valid", 32'(out_valid), 32'(ev));
        checkOutput("in_ready", 32'(in_ready), 32'(eir));
        if (ev) begin
            checkOutput("group", 32'(out_group), 32'(q[0].group));
            checkOutput("operator", 32'(out_operator), 32'(q[0].op));
            checkOutput("rgv", 32'(out_rgv), 32'(q[0].rgv));
            checkOutput("rg1", 32'(out_rg1), 32'(q[0].rg1));
            checkOutput("rg2", 32'(out_rg2), 32'(q[0].rg2));
            checkOutput("val", 32'(out_val), 32'(q[0].val));
            checkOutput("rel", 32'(out_rel), 32'(q[0].rel));
            checkOutput("pc", 32'(out_pc), 32'(q[0].pc));
            checkOutput("ext", 32'(out_ext), 32'(q[0].ext));
            checkOutput("illegal", 32'(out_illegal), 32'(q[0].ill));
            if (out_ready) void'(q.pop_front());
        end
        if (flush) begin
            q.delete();
            pend = 1'b0;
        end else if (in_valid && eir) begin
            modelAccept(in_word, in_pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] w, input logic [AW-1:0] pc,
                                 input logic v, input logic r, input logic f);
        in_word   = w;
        in_pc     = pc;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        tick();
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_group", 32'(out_group), 32'd0);
        checkOutput("rst_val", 32'(out_val), 32'd0);
        checkOutput("rst_rel", 32'(out_rel), 32'd0);
        checkOutput("rst_pc", 32'(out_pc), 32'd0);
        checkOutput("rst_ext", 32'(out_ext), 32'd0);
        checkOutput("rst_illegal", 32'(out_illegal), 32'd0);
        q.delete();
        pend = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        reset     = 1'b0;
        flush     = 1'b0;
        in_word   = '0;
        in_pc     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pend      = 1'b0;
        ph        = 0;
        ppc       = '0;
        #3;
        doReset();

        // Streaming two plain words with one-cycle latency
        applyStimulus(16'h3A52, 20'h00100, 1'b1, 1'b1, 1'b0);
        checkOutput("t1_val", 32'(out_val), 32'h00A5);
        applyStimulus(16'h0018, 20'h00101, 1'b1, 1'b1, 1'b0);
        checkOutput("t1_rel", 32'(out_rel), 32'h0);
        applyStimulus(16'h0000, 20'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(16'h0000, 20'h0, 1'b0, 1'b1, 1'b0);

        // Prefix widening the immediate
        applyStimulus(16'hAB1A, 20'h00010, 1'b1, 1'b1, 1'b0);
        checkOutput("t2_noout", 32'(out_valid), 32'd0);
        applyStimulus(16'h0CD2, 20'h00011, 1'b1, 1'b1, 1'b0);
        checkOutput("t2_val", 32'(out_val), 32'hABCD);
        checkOutput("t2_ext", 32'(out_ext), 32'd1);
        checkOutput("t2_pc", 32'(out_pc), 32'h10);
        applyStimulus(16'h0000, 20'h0, 1'b0, 1'b1, 1'b0);

        // Jump offset sign extension, plain and widened
        applyStimulus(16'hFFF0, 20'h00200, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_rel", 32'(out_rel), 32'hFFFFF);
        applyStimulus(16'h801A, 20'h00201, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h0010, 20'h00202, 1'b1, 1'b1, 1'b0);
        checkOutput("t3_rel_ext", 32'(out_rel), 32'hC0000);
        applyStimulus(16'h0000, 20'h0, 1'b0, 1'b1, 1'b0);

        // Back-pressure: hold three cycles with a word waiting
        applyStimulus(16'h1234, 20'h00300, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h5678, 20'h00301, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_stall", 32'(in_ready), 32'd0);
        applyStimulus(16'h5678, 20'h00301, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h5678, 20'h00301, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h5678, 20'h00301, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h0000, 20'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(16'h0000, 20'h0, 1'b0, 1'b1, 1'b0);

        // Prefix followed by a non-extendable word, then prefix + prefix
        applyStimulus(16'h221A, 20'h00400, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h111D, 20'h00401, 1'b1, 1'b1, 1'b0);
        checkOutput("t5_ill", 32'(out_illegal), 32'd1);
        checkOutput("t5_ext", 32'(out_ext), 32'd1);
        applyStimulus(16'h331A, 20'h00500, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h441A, 20'h00501, 1'b1, 1'b1, 1'b0);
        checkOutput("t5_pp_group", 32'(out_group), 32'd0);
        checkOutput("t5_pp_pc", 32'(out_pc), 32'h500);
        applyStimulus(16'h0000, 20'h0, 1'b0, 1'b1, 1'b0);

        // Flush while holding a prefix, then flush with a bundle pending
        applyStimulus(16'h551A, 20'h00600, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h0010, 20'h00601, 1'b1, 1'b1, 1'b1);
        applyStimulus(16'h0010, 20'h00602, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_ext", 32'(out_ext), 32'd0);
        checkOutput("t6_rel", 32'(out_rel), 32'd0);
        applyStimulus(16'h0123, 20'h00603, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h0000, 20'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h0000, 20'h0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset while a prefix is held
        applyStimulus(16'h661A, 20'h00700, 1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        doReset();
        applyStimulus(16'h0010, 20'h00701, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_rst_ext", 32'(out_ext), 32'd0);
        applyStimulus(16'h0000, 20'h0, 1'b0, 1'b1, 1'b0);

        // Random traffic with frequent prefixes, stalls and occasional flushes
        for (int i = 0; i < 400; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[4:0] = 5'b11010;
            applyStimulus(w, AW'($urandom),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h0000, 20'h0, 1'b0, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
